// File: rtl/prbs7_checker.sv
// -----------------------------------------------------------------------------
// prbs7_checker
//
// Self-synchronising PRBS7 (x^7 + x^6 + 1) receive checker, one 8-bit word per
// valid cycle, data_in[7] earliest in time. A HUNT -> SYNC -> LOCKED state
// machine qualifies the link. Bit errors are accumulated only while LOCKED.
//
// Parameters
//   LOCK_WORDS    consecutive clean words in SYNC needed to lock    (1..255)
//   UNLOCK_WORDS  consecutive errored words in LOCKED to drop lock  (1..255)
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   enable      in   data_in valid this cycle
//   data_in     in   [7:0] received word, bit 7 first
//   clear       in   synchronous clear of the statistics counters
//   locked      out  checker is in LOCKED
//   err         out  one-cycle pulse: last word (while LOCKED) had errors
//   err_count   out  [31:0] saturating sum of bit-error flags
//   word_count  out  [31:0] saturating count of valid words seen while LOCKED
//                    (present only when PRBS7_CHECKER_WORDCNT_EN is defined)
//
// Optional feature macro: PRBS7_CHECKER_WORDCNT_EN
// -----------------------------------------------------------------------------
module prbs7_checker #(
    parameter int LOCK_WORDS   = 16,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [7:0]  data_in,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic [31:0] err_count
`ifdef PRBS7_CHECKER_WORDCNT_EN
    ,
    output logic [31:0] word_count
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Terminal values of the run counters (counter value before the last word).
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_WORDS - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_WORDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_hist;
    logic [7:0]  r_run;
    logic [7:0]  w_run_nxt;
    logic [7:0]  r_bad;
    logic [7:0]  w_bad_nxt;
    logic        r_locked;
    logic        r_err;
    logic [31:0] r_err_count;
    logic [31:0] w_err_count_nxt;
    logic [32:0] w_err_sum;
    logic [7:0]  w_flags;
    logic [3:0]  w_flag_cnt;
    logic        w_word_err;
    logic        w_count_word;

    // Per-bit error flags, aligned with data bit positions. hist[0] is the most
    // recent received bit. Each bit is predicted from the bits 6 and 7
    // positions earlier in the serial stream, which may come from this word.
    function automatic logic [7:0] prbs7_flags(input logic [6:0] hist,
                                               input logic [7:0] data);
        logic [14:0] seq;
        logic [7:0]  f;
        seq = 15'd0;
        f   = 8'd0;
        for (int i = 0; i < 7; i++) begin
            seq[i] = hist[6 - i];
        end
        for (int j = 0; j < 8; j++) begin
            seq[7 + j] = data[7 - j];
        end
        for (int j = 0; j < 8; j++) begin
            f[7 - j] = seq[7 + j] ^ seq[j + 1] ^ seq[j];
        end
        // All-zero / all-one words cannot occur in PRBS7; a dead or stuck
        // link would otherwise look clean to the self-synchronising predictor.
        if ((data == 8'h00) || (data == 8'hFF)) begin
            f = 8'hFF;
        end else begin
            f = f;
        end
        return f;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    // Word evaluation against the stored history.
    always_comb begin
        w_flags      = prbs7_flags(r_hist, data_in);
        w_flag_cnt   = popcount8(w_flags);
        w_word_err   = (w_flags != 8'h00);
        w_count_word = enable && (r_state == LOCKED);
    end

    // Lock state machine: next state and run counters.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_bad_nxt   = r_bad;
        if (enable) begin
            case (r_state)
                HUNT: begin
                    // First word only primes the history.
                    w_state_nxt = SYNC;
                    w_run_nxt   = 8'd0;
                    w_bad_nxt   = 8'd0;
                end
                SYNC: begin
                    if (w_word_err) begin
                        w_run_nxt = 8'd0;
                    end else if (r_run == LOCK_LAST) begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = 8'd0;
                        w_bad_nxt   = 8'd0;
                    end else begin
                        w_run_nxt = r_run + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!w_word_err) begin
                        w_bad_nxt = 8'd0;
                    end else if (r_bad == UNLOCK_LAST) begin
                        w_state_nxt = HUNT;
                        w_run_nxt   = 8'd0;
                        w_bad_nxt   = 8'd0;
                    end else begin
                        w_bad_nxt = r_bad + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_run_nxt   = 8'd0;
                    w_bad_nxt   = 8'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run;
            w_bad_nxt   = r_bad;
        end
    end

    // Saturating error accumulator; clear takes priority over an increment.
    always_comb begin
        w_err_sum = {1'b0, r_err_count} + {29'd0, w_flag_cnt};
        if (clear) begin
            w_err_count_nxt = 32'd0;
        end else if (w_count_word) begin
            if (w_err_sum[32]) begin
                w_err_count_nxt = 32'hFFFF_FFFF;
            end else begin
                w_err_count_nxt = w_err_sum[31:0];
            end
        end else begin
            w_err_count_nxt = r_err_count;
        end
    end

    // State, history and run counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= HUNT;
            r_hist  <= 7'd0;
            r_run   <= 8'd0;
            r_bad   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_bad   <= w_bad_nxt;
            if (enable) begin
                r_hist <= data_in[6:0];
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 32'd0;
        end else begin
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_count_word && w_word_err;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;

`ifdef PRBS7_CHECKER_WORDCNT_EN
    logic [31:0] r_word_count;

    // Saturating count of valid words observed while LOCKED.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_word_count <= 32'd0;
        end else if (clear) begin
            r_word_count <= 32'd0;
        end else if (w_count_word && (r_word_count != 32'hFFFF_FFFF)) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs7_checker
//
// Directed bench for prbs7_checker. The stimulus process drives one word per
// cycle on the falling edge and queues the expected registered outputs for the
// following rising edge; a monitor process pops and compares one entry after
// each rising edge. The asynchronous-reset check is sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_prbs7_checker;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic [7:0]  data_in;
    logic        clear;
    logic        locked;
    logic        err;
    logic [31:0] err_count;
`ifdef PRBS7_CHECKER_WORDCNT_EN
    logic [31:0] word_count;
`endif

    typedef struct packed {
        logic        l;
        logic        e;
        logic [31:0] c;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    logic [6:0] gen_st;

    prbs7_checker #(.LOCK_WORDS(16), .UNLOCK_WORDS(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (enable),
        .data_in   (data_in),
        .clear     (clear),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
`ifdef PRBS7_CHECKER_WORDCNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Reference PRBS7 generator, gen_st[0] is the most recent bit.
    task automatic gen_word(output logic [7:0] w);
        logic b;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b      = gen_st[5] ^ gen_st[6];
            gen_st = {gen_st[5:0], b};
            w      = {w[6:0], b};
        end
    endtask

    function automatic bit is_special(input logic [7:0] v);
        return (v == 8'h00) || (v == 8'hFF);
    endfunction

    task automatic drive(input logic en, input logic [7:0] d, input logic clr,
                         input logic el, input logic ee, input logic [31:0] ec,
                         input string nm);
        exp_t x;
        @(negedge sys_clk);
        enable  = en;
        data_in = d;
        clear   = clr;
        x.l = el;
        x.e = ee;
        x.c = ec;
        sb_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: compare outputs after each rising edge against the queue.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if ((locked !== e.l) || (err !== e.e) || (err_count !== e.c)) begin
                    n_miss++;
                    $display("FAIL %s: locked/err/err_count got %0b/%0b/%h want %0b/%0b/%h",
                             nm, locked, err, err_count, e.l, e.e, e.c);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0]  w;
        logic [7:0]  wf;
        logic [31:0] ec;
        sys_rst_n = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        data_in   = 8'h00;
        gen_st    = 7'd1;
        ec        = 32'd0;

        // Reset state.
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, "reset");
        sys_rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, "idle_after_reset");

        // Clean lock: first word 8'h06, lock after the 17th word.
        for (int k = 1; k <= 17; k++) begin
            gen_word(w);
            if (k == 1) chk("first_word_is_06", {24'd0, w}, 32'h0000_0006);
            drive(1'b1, w, 1'b0, (k == 17), 1'b0, 32'd0, "clean_lock");
        end

        // Single-bit flip on data bit 3: 1 flag now, 2 in the next word.
        gen_word(w);
        wf = w ^ 8'h08;
        ec = is_special(wf) ? 32'd8 : 32'd1;
        drive(1'b1, wf, 1'b0, 1'b1, 1'b1, ec, "flip_word");
        gen_word(w);
        ec = ec + 32'd2;
        drive(1'b1, w, 1'b0, 1'b1, 1'b1, ec, "flip_next");
        gen_word(w);
        drive(1'b1, w, 1'b0, 1'b1, 1'b0, ec, "flip_clean");

        // Stuck link: four all-zero words, lock drops after the 4th.
        for (int k = 1; k <= 4; k++) begin
            ec = ec + 32'd8;
            drive(1'b1, 8'h00, 1'b0, (k < 4), 1'b1, ec, "stuck");
        end

        // Relock with enable alternating; idle data must be ignored.
        for (int k = 1; k <= 17; k++) begin
            gen_word(w);
            drive(1'b1, w, 1'b0, (k == 17), 1'b0, ec, "gap_valid");
            drive(1'b0, 8'hFF, 1'b0, (k == 17), 1'b0, ec, "gap_idle");
        end

        // Asynchronous reset between edges while locked with a nonzero count.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, "rst_cycle");
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_locked", {31'd0, locked}, 32'd0);
        chk("async_rst_err_count", err_count, 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0, "rst_hold");
        sys_rst_n = 1'b1;
        ec = 32'd0;

        // Full relock after reset.
        for (int k = 1; k <= 17; k++) begin
            gen_word(w);
            drive(1'b1, w, 1'b0, (k == 17), 1'b0, 32'd0, "relock");
        end

        // Clear wins over a same-cycle increment. Bit-7 flips give 3 flags.
        gen_word(w);
        wf = w ^ 8'h80;
        ec = is_special(wf) ? 32'd8 : 32'd3;
        drive(1'b1, wf, 1'b0, 1'b1, 1'b1, ec, "err_before_clear");
        gen_word(w);
        wf = w ^ 8'h80;
        drive(1'b1, wf, 1'b1, 1'b1, 1'b1, 32'd0, "clear_wins");
        gen_word(w);
        drive(1'b1, w, 1'b0, 1'b1, 1'b0, 32'd0, "after_clear");

        // Saturation from a preloaded near-full counter.
        gen_word(w);
        wf = w ^ 8'h80;
        drive(1'b1, wf, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, "sat_hit");
        force dut.r_err_count = 32'hFFFF_FFFE;
        #1 release dut.r_err_count;
        gen_word(w);
        drive(1'b1, w, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, "sat_clean");
        gen_word(w);
        wf = w ^ 8'h80;
        drive(1'b1, wf, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, "sat_hold");

        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, "final_idle");
        repeat (3) @(negedge sys_clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 SHALL have parameter LOCK_WORDS, default 16: consecutive error-free words required to declare lock (range 1..255).
REQ-002 SHALL have parameter UNLOCK_WORDS, default 4: consecutive errored words that drop lock (range 1..255).
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: data_in is valid this cycle.
REQ-006 SHALL have port data_in, input, 8 bits: received PRBS7 word, bit 7 earliest in time.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of the statistics counters.
REQ-008 SHALL have port locked, output, 1 bit: the checker is in state LOCKED.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse when the last word counted at least one error.
REQ-010 SHALL have port err_count, output, 32 bits: accumulated bit-error flags.

Function
REQ-011 SHALL check the sequence x[n] = x[n-6] XOR x[n-7] (x^7+x^6+1), serial order data_in[7] first.
REQ-012 SHALL self-synchronise: a 7-bit history of received bits, plus earlier bits of the same word, predict each bit; flag[i] = received XOR predicted.
REQ-013 SHALL treat data_in = 8'h00 or 8'hFF as an errored word with 8 flags, because PRBS7 has no such run.
REQ-014 SHALL load the history only on cycles where enable=1; enable=0 holds all state, and err is 0 on those cycles.
REQ-015 SHALL register every output, with 1-cycle latency: word sampled at edge k, result visible after edge k.
REQ-016 SHALL implement FSM HUNT, SYNC and LOCKED; locked=1 only in LOCKED.
REQ-017 HUNT: the first valid word only loads history, with no checking, then goes to SYNC with run counter 0.
REQ-018 SYNC: a clean word increments the run counter; an errored word zeroes it; at LOCK_WORDS clean words go to LOCKED.
REQ-019 LOCKED: an errored word increments the bad-run counter and a clean word zeroes it; at UNLOCK_WORDS go to HUNT.
REQ-020 SHALL add popcount(flags), 0..8, to err_count and pulse err only in LOCKED; HUNT and SYNC never count.
REQ-021 SHALL saturate err_count at 32'hFFFF_FFFF, with no wrap.
REQ-022 clear SHALL zero err_count (and word_count) and win over a same-cycle increment; FSM and history are unaffected.

Reset
REQ-023 While sys_rst_n=0, state SHALL be HUNT, history 0, run counters 0, locked=0, err=0, err_count=0, word_count=0.
REQ-024 Reset asserted mid-operation SHALL clear immediately, without waiting for a clock edge, and relock SHALL require the full HUNT/SYNC sequence.

Configuration
REQ-025 SHALL compile in, with macro PRBS7_CHECKER_WORDCNT_EN defined, output word_count (32 bits): count of valid words in LOCKED, saturating, cleared by clear/reset.
REQ-026 Without PRBS7_CHECKER_WORDCNT_EN, the word_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover clean lock: after reset, generator seeded 7'd1 (first word 8'h06), enable=1 continuously -> locked rises after the 17th word's edge, with err_count=0.
REQ-028 SHALL cover single-bit flip: while locked, invert one bit -> err_count +3 total (possibly across two words), err pulses, and locked stays 1.
REQ-029 SHALL cover stuck link: while locked, data_in=8'h00 for 4 words -> err_count +32, and locked falls after the 4th word.
REQ-030 SHALL cover gaps and clear: enable toggled 1/0 every cycle -> lock after 17 valid words; clear=1 with an errored word -> err_count=0 next cycle.
REQ-031 SHALL cover async reset: sys_rst_n low mid-lock, between edges -> locked=0 and err_count=0 before the next edge; relock takes 17 words.
REQ-032 SHALL cover saturation: preload or force err_count to 32'hFFFF_FFFE, inject a 3-flag error -> value stays 32'hFFFF_FFFF.
